// File: rtl/col_parity_engine.sv
// Column-parity transform engine over DEPTH 25-bit slices held in an external
// synchronous-read memory; results are written back in place or to a copy.
module col_parity_engine #(
    parameter int DEPTH = 64,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    output logic [AW-1:0] rd_addr,
    input  logic [24:0]   line_in,
    output logic          write_enable,
    output logic [AW-1:0] cnt_value,
    output logic [24:0]   write_value,
    output logic          busy,
    output logic          donee
);

    typedef enum logic [2:0] {IDLE, PRELOAD, PRIME, RUN, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state, state_nx;
    logic [AW-1:0] cnt;
    logic [4:0]    c_prev;
    logic [4:0]    c_cur;
    logic          mode_r;
    logic [24:0]   f_out;

    function automatic logic [4:0] parity(input logic [24:0] s);
        logic [4:0] c;
        c = '0;
        for (int unsigned y = 0; y < 5; y++)
            for (int unsigned x = 0; x < 5; x++)
                c[x] = c[x] ^ s[5*y+x];
        return c;
    endfunction

    always_comb begin
        c_cur = parity(line_in);
    end

    always_comb begin
        f_out = '0;
        for (int unsigned y = 0; y < 5; y++)
            for (int unsigned x = 0; x < 5; x++)
                f_out[5*y+x] = line_in[5*y+x] ^
                               (~mode_r & (c_cur[(x+4)%5] ^ c_prev[(x+1)%5]));
    end

    // Read address leads the write pipeline by two: DEPTH-1 first, then 0..DEPTH.
    always_comb begin
        state_nx = state;
        rd_addr  = '0;
        unique case (state)
            IDLE:    if (start) state_nx = PRELOAD;
            PRELOAD: begin
                rd_addr  = LAST;
                state_nx = PRIME;
            end
            PRIME:   state_nx = RUN;
            RUN: begin
                rd_addr = cnt + AW'(1);
                if (cnt == LAST) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            c_prev       <= '0;
            mode_r       <= 1'b0;
            cnt_value    <= '0;
            write_value  <= '0;
            write_enable <= 1'b0;
            busy         <= 1'b0;
            donee        <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            donee        <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt  <= '0;
                    busy <= start;
                    if (start) mode_r <= mode;
                end
                PRELOAD: ;
                PRIME:   c_prev <= c_cur;
                RUN: begin
                    c_prev       <= c_cur;
                    write_enable <= 1'b1;
                    cnt_value    <= cnt;
                    write_value  <= f_out;
                    if (cnt != LAST) cnt <= cnt + AW'(1);
                end
                DONE:    donee <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_col_parity_engine.sv
// Bench for col_parity_engine: two instances (DEPTH 64 and DEPTH 4) each backed
// by an in-place memory model, checked cycle by cycle against a slice-level model.
module tb_col_parity_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DEPTH = 64 instance
    logic        rst64 = 1'b0, start64 = 1'b0, mode64 = 1'b0;
    logic [6:0]  rd64, cnt64;
    logic [24:0] line64 = '0, wv64;
    logic        we64, busy64, done64;
    logic [24:0] mem64 [64];
    logic [24:0] img64 [64];
    logic        load64 = 1'b0;

    col_parity_engine #(.DEPTH(64), .AW(7)) u64 (
        .clk(clk), .rst(rst64), .start(start64), .mode(mode64),
        .rd_addr(rd64), .line_in(line64), .write_enable(we64),
        .cnt_value(cnt64), .write_value(wv64), .busy(busy64), .donee(done64)
    );

    always @(posedge clk) begin
        if (load64) mem64 <= img64;
        else begin
            line64 <= mem64[rd64[5:0]];
            if (we64) mem64[cnt64[5:0]] <= wv64;
        end
    end

    // DEPTH = 4 instance
    logic        rst4 = 1'b0, start4 = 1'b0, mode4 = 1'b0;
    logic [2:0]  rd4, cnt4;
    logic [24:0] line4 = '0, wv4;
    logic        we4, busy4, done4;
    logic [24:0] mem4 [4];
    logic [24:0] img4 [4];
    logic        load4 = 1'b0;

    col_parity_engine #(.DEPTH(4), .AW(3)) u4 (
        .clk(clk), .rst(rst4), .start(start4), .mode(mode4),
        .rd_addr(rd4), .line_in(line4), .write_enable(we4),
        .cnt_value(cnt4), .write_value(wv4), .busy(busy4), .donee(done4)
    );

    always @(posedge clk) begin
        if (load4) mem4 <= img4;
        else begin
            line4 <= mem4[rd4[1:0]];
            if (we4) mem4[cnt4[1:0]] <= wv4;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] par(input logic [24:0] s);
        logic [4:0] c = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                c[x] ^= s[5*y+x];
        return c;
    endfunction

    // Slice transform: own column parity shifted one way, neighbour-slice parity the other.
    function automatic logic [24:0] xform(input logic [24:0] s, input logic [24:0] prev,
                                          input logic m);
        logic [4:0]  cs = par(s);
        logic [4:0]  cp = par(prev);
        logic [24:0] r  = s;
        if (!m)
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    r[5*y+x] ^= cs[(x+4)%5] ^ cp[(x+1)%5];
        return r;
    endfunction

    task automatic load_img64();
        @(negedge clk) load64 = 1'b1;
        @(negedge clk) load64 = 1'b0;
    endtask

    // One full DEPTH=64 run from the current memory, with cycle-exact checks.
    task automatic run64(input logic m, input bit pulse_busy);
        logic [24:0] orig [64];
        logic [24:0] exp  [64];
        bit          we_exp;
        orig = mem64;
        for (int k = 0; k < 64; k++) exp[k] = xform(orig[k], orig[(k+63)%64], m);
        @(negedge clk);
        mode64  = m;
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        mode64  = ~m;
        for (int cyc = 1; cyc <= 72; cyc++) begin
            we_exp = (cyc >= 4) && (cyc <= 67);
            chk("we64", {31'd0, we64}, {31'd0, we_exp});
            if (we_exp) begin
                chk("addr64", {25'd0, cnt64}, 32'(cyc - 4));
                chk("data64", {7'd0, wv64}, {7'd0, exp[cyc-4]});
            end
            chk("done64", {31'd0, done64}, {31'd0, cyc == 68});
            chk("busy64", {31'd0, busy64}, {31'd0, cyc <= 68});
            start64 = pulse_busy && (cyc == 30 || cyc == 67);
            @(negedge clk);
        end
        start64 = 1'b0;
        for (int k = 0; k < 64; k++) chk("mem64", {7'd0, mem64[k]}, {7'd0, exp[k]});
    endtask

    initial begin
        logic [24:0] model4 [4];
        logic [24:0] exp4 [3][4];
        int          r, k;
        bit          we_exp;

        // Reset state
        #12;
        chk("rst_we", {31'd0, we64}, 32'd0);
        chk("rst_busy", {31'd0, busy64}, 32'd0);
        chk("rst_done", {31'd0, done64}, 32'd0);
        chk("rst_rd", {25'd0, rd64}, 32'd0);
        chk("rst_cnt", {25'd0, cnt64}, 32'd0);
        chk("rst_wv", {7'd0, wv64}, 32'd0);
        @(negedge clk);
        rst64 = 1'b1;
        rst4  = 1'b1;

        // Zero memory, transform
        for (int i = 0; i < 64; i++) img64[i] = '0;
        load_img64();
        run64(1'b0, 1'b0);

        // Single set bit in slice 63 exercises the z wrap-around
        for (int i = 0; i < 64; i++) img64[i] = '0;
        img64[63] = 25'h1;
        load_img64();
        run64(1'b0, 1'b0);
        chk("wrap_s0", {7'd0, mem64[0]}, 32'h1084210);
        chk("wrap_s63", {7'd0, mem64[63]}, 32'h0210843);
        chk("wrap_s1", {7'd0, mem64[1]}, 32'h0);

        // Random memory, transform; stray starts while busy/DONE must be ignored
        for (int i = 0; i < 64; i++) img64[i] = 25'($urandom);
        load_img64();
        run64(1'b0, 1'b1);

        // Random memory, copy
        for (int i = 0; i < 64; i++) img64[i] = 25'($urandom);
        load_img64();
        run64(1'b1, 1'b1);
        for (int i = 0; i < 64; i++) chk("copy64", {7'd0, mem64[i]}, {7'd0, img64[i]});

        // Reset in cycle 20 of a run
        for (int i = 0; i < 64; i++) img64[i] = 25'($urandom);
        load_img64();
        @(negedge clk);
        mode64  = 1'b0;
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        for (int cyc = 1; cyc < 20; cyc++) @(negedge clk);
        chk("pre_rst_we", {31'd0, we64}, 32'd1);
        rst64 = 1'b0;
        #1;
        chk("mid_rst_we", {31'd0, we64}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy64}, 32'd0);
        chk("mid_rst_rd", {25'd0, rd64}, 32'd0);
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            chk("rst_hold_we", {31'd0, we64}, 32'd0);
        end
        rst64 = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            chk("post_rst_we", {31'd0, we64}, 32'd0);
            chk("post_rst_done", {31'd0, done64}, 32'd0);
            chk("post_rst_busy", {31'd0, busy64}, 32'd0);
        end
        run64(1'b0, 1'b0);

        // DEPTH = 4, start held high for 20 cycles: three back-to-back runs
        for (int i = 0; i < 4; i++) img4[i] = 25'($urandom);
        @(negedge clk) load4 = 1'b1;
        @(negedge clk) load4 = 1'b0;
        model4 = img4;
        for (int run = 0; run < 3; run++) begin
            for (int j = 0; j < 4; j++) exp4[run][j] = xform(model4[j], model4[(j+3)%4], 1'b0);
            model4 = exp4[run];
        end
        @(negedge clk);
        mode4  = 1'b0;
        start4 = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 28; cyc++) begin
            r = (cyc - 4) / 8;
            k = (cyc - 4) % 8;
            we_exp = (cyc >= 4) && (k < 4) && (r < 3);
            chk("we4", {31'd0, we4}, {31'd0, we_exp});
            if (we_exp) begin
                chk("addr4", {29'd0, cnt4}, 32'(k));
                chk("data4", {7'd0, wv4}, {7'd0, exp4[r][k]});
            end
            chk("done4", {31'd0, done4}, {31'd0, cyc == 8 || cyc == 16 || cyc == 24});
            chk("busy4", {31'd0, busy4}, {31'd0, cyc <= 24});
            start4 = (cyc <= 19);
            @(negedge clk);
        end
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) chk("mem4", {7'd0, mem4[i]}, {7'd0, model4[i]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/col_parity_engine.md
COL_PARITY_ENGINE -- requirements
Module: col_parity_engine

Interface
REQ-001 Parameter DEPTH, default 64: number of 25-bit slices (memory lines) processed per run; legal range 2..1024.
REQ-002 Parameter AW, default 7: address/count width; SHALL satisfy 2^AW > DEPTH-1.
REQ-003 Clock, reset and start: clk, in, 1: single clock, rising edge. rst, in, 1: reset, asynchronous, active-low. start, in, 1: run request, sampled in IDLE only.
REQ-004 mode, in, 1: 0 = column-parity transform, 1 = copy; sampled with start.
REQ-005 rd_addr, out, AW: read address of the slice; the memory returns that slice on line_in one cycle later.
REQ-006 line_in, in, 25: slice data; bit index 5*y+x, where x is the column 0..4 and y is the row 0..4.
REQ-007 write_enable, out, 1: write strobe, registered.
REQ-008 cnt_value, out, AW: write address, registered.
REQ-009 write_value, out, 25: write data, registered.
REQ-010 busy, out, 1: high from the cycle after start is accepted until DONE is left.
REQ-011 donee, out, 1: one-cycle completion pulse.

Function
REQ-012 FSM SHALL have five states: IDLE, PRELOAD, PRIME, RUN, DONE.
REQ-013 IDLE to PRELOAD on start=1; mode latched on the same edge.
REQ-014 PRELOAD, one cycle: rd_addr = DEPTH-1.
REQ-015 PRIME, one cycle: C_prev <= parity(line_in), i.e. slice DEPTH-1; rd_addr = 0.
REQ-016 RUN, DEPTH cycles, k = 0..DEPTH-1: line_in holds slice k; rd_addr = k+1 (value unused in the last RUN cycle).
REQ-017 In each RUN cycle: C_prev <= parity(slice k) for use by slice k+1.
REQ-018 In each RUN cycle, on the next edge: write_enable <= 1, cnt_value <= k, write_value <= f(slice k).
REQ-019 parity: C[x] = XOR over y of bit[5y+x].
REQ-020 f in mode 0: out[5y+x] = in[5y+x] ^ C_cur[(x+4)%5] ^ C_prev[(x+1)%5].
REQ-021 f in mode 1: out = in; the parity registers SHALL still update.
REQ-022 Slice 0 SHALL use the parity of slice DEPTH-1 (z wrap-around); all other slices use slice k-1.
REQ-023 All parity inputs SHALL come from the original data: reads lead writes by 2 addresses, so an in-place memory is safe.
REQ-024 RUN to DONE after the k = DEPTH-1 cycle; the last write is issued on that edge.
REQ-025 DONE, one cycle: donee = 1, write_enable = 0; next state IDLE.
REQ-026 Timing, start sampled at edge 0: write k is presented in cycle k+4; donee in cycle DEPTH+4 (68 for DEPTH = 64).
REQ-027 write_enable SHALL be high exactly DEPTH cycles per run, with contiguous ascending addresses.
REQ-028 start while busy or in DONE SHALL be ignored; runs are not queued.
REQ-029 start held high continuously SHALL begin a new run on the IDLE cycle after DONE.
REQ-030 Internal slice counter SHALL be AW bits wide and SHALL NOT wrap within a run.

Reset
REQ-031 rst = 0 SHALL immediately force IDLE and clear C_prev, mode, rd_addr, cnt_value, write_value, write_enable, busy and donee to 0.
REQ-032 Reset mid-run: no further writes are issued, donee is not pulsed, and the run is lost; the first start after rst = 1 begins a clean run.

Verification
REQ-033 Zero memory, DEPTH = 64, mode 0 -> 64 writes of 0 at cnt_value 0..63 in cycles 4..67; donee in cycle 68.
REQ-034 Only slice 63 bit 0 set, mode 0 -> slice 0 written 25'h1084210, slice 63 written 25'h0210843, all others 0.
REQ-035 Random memory, mode 1 -> every written slice equals its original; busy high for 68 cycles.
REQ-036 rst pulled low in cycle 20 of a run -> write_enable = 0 in the same cycle and no donee; after release, start completes a full correct run.
REQ-037 DEPTH = 4, start held high for 20 cycles -> back-to-back runs of 8 cycles each (donee at cycle 8), one IDLE cycle between runs; starts pulsed during busy ignored.
